// File: rtl/pong_pkg.sv
// Shared PS/2 definitions for the pong codebase.
// Holds the command bytes sent to the keyboard, the error codes that
// accompany an err pulse, and the host transmitter state encoding.
package pong_pkg;

    localparam logic [7:0] PS2_CMD_RESET  = 8'hFF;
    localparam logic [7:0] PS2_CMD_LEDS   = 8'hED;
    localparam logic [7:0] PS2_CMD_ENABLE = 8'hF4;

    localparam logic [1:0] PS2_ERR_NONE    = 2'b00;
    localparam logic [1:0] PS2_ERR_NACK    = 2'b01;
    localparam logic [1:0] PS2_ERR_REQ_TO  = 2'b10;
    localparam logic [1:0] PS2_ERR_XFER_TO = 2'b11;

    typedef enum logic [2:0] {
        PS2_IDLE,
        PS2_INHIBIT,
        PS2_START,
        PS2_RELEASE,
        PS2_SHIFT,
        PS2_ACK,
        PS2_WAITIDLE
    } ps2_tx_state_e;

endpackage

// File: rtl/ps2_sync_edge.sv
// Two-flop synchroniser for a raw PS/2 line plus a one-cycle falling-edge
// pulse. Shared by the host transmitter and the receive path.
//   clk    in  system clock
//   reset  in  asynchronous active-low reset
//   din    in  raw asynchronous line
//   sync   out synchronised line level
//   fall   out 1-cycle pulse when the synchronised level goes 1 -> 0
module ps2_sync_edge (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic sync,
    output logic fall
);

    logic meta_q, sync_q, prev_q;
    logic meta_d, sync_d, prev_d;

    always_comb begin
        meta_d = din;
        sync_d = meta_q;
        prev_d = sync_q;
    end

    // Idle PS/2 lines are pulled high; resetting to 1 avoids a false fall.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
            prev_q <= 1'b1;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign sync = sync_q;
    assign fall = prev_q & ~sync_q;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: sends one command byte to the keyboard.
//   clk, reset            system clock, asynchronous active-low reset
//   tx_data/valid/ready   command byte handshake (accepted on valid & ready)
//   busy                  transfer in flight, receive path ignores device clocks
//   done / err            1-cycle completion pulses; err_code valid with err
//                         (01 nack, 10 request timeout, 11 transfer timeout)
//   ps2_clk_i/ps2_data_i  raw open-drain line levels
//   ps2_clk_oe/data_oe    1 = pull the line low
module ps2_host_tx
    import pong_pkg::*;
#(
    parameter int unsigned CLK_HZ      = 100_000_000,
    parameter int unsigned INHIBIT_CYC = CLK_HZ / 1_000_000 * 120,
    parameter int unsigned REQ_TO_CYC  = CLK_HZ / 1000 * 15,
    parameter int unsigned XFER_TO_CYC = CLK_HZ / 1000 * 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic [1:0] err_code,
    input  logic       ps2_clk_i,
    input  logic       ps2_data_i,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe
);

    localparam int unsigned TMO_W = $clog2(REQ_TO_CYC + 1);

    ps2_tx_state_e    state_q, state_d;
    logic [3:0]       bit_q, bit_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic [8:0]       sh_q, sh_d;
    logic             drive_q, drive_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic [1:0]       err_code_q, err_code_d;

    logic clk_sync, clk_fall, data_sync, unused_data_fall;

    ps2_sync_edge u_clk_sync (
        .clk   (clk),
        .reset (reset),
        .din   (ps2_clk_i),
        .sync  (clk_sync),
        .fall  (clk_fall)
    );

    ps2_sync_edge u_data_sync (
        .clk   (clk),
        .reset (reset),
        .din   (ps2_data_i),
        .sync  (data_sync),
        .fall  (unused_data_fall)
    );

    logic xfer_expired;
    assign xfer_expired = (tmo_q == TMO_W'(XFER_TO_CYC - 1));

    always_comb begin
        state_d    = state_q;
        bit_d      = bit_q;
        tmo_d      = tmo_q + TMO_W'(1);
        sh_d       = sh_q;
        drive_d    = drive_q;
        done_d     = 1'b0;
        err_d      = 1'b0;
        err_code_d = PS2_ERR_NONE;

        unique case (state_q)
            PS2_IDLE: begin
                tmo_d   = '0;
                bit_d   = '0;
                drive_d = 1'b0;
                if (tx_valid) begin
                    sh_d    = {~^tx_data, tx_data};
                    state_d = PS2_INHIBIT;
                end
            end
            PS2_INHIBIT: begin
                if (tmo_q == TMO_W'(INHIBIT_CYC - 1)) begin
                    tmo_d   = '0;
                    state_d = PS2_START;
                end
            end
            PS2_START: begin
                tmo_d   = '0;
                state_d = PS2_RELEASE;
            end
            PS2_RELEASE: begin
                if (clk_fall) begin
                    drive_d = ~sh_q[0];
                    sh_d    = sh_q >> 1;
                    bit_d   = 4'd1;
                    tmo_d   = '0;
                    state_d = PS2_SHIFT;
                end else if (tmo_q == TMO_W'(REQ_TO_CYC - 1)) begin
                    err_d      = 1'b1;
                    err_code_d = PS2_ERR_REQ_TO;
                    state_d    = PS2_IDLE;
                end
            end
            // The transfer timeout is one budget from fall 1 to line idle,
            // so the counter is not cleared between SHIFT, ACK and WAITIDLE.
            PS2_SHIFT: begin
                if (xfer_expired) begin
                    err_d      = 1'b1;
                    err_code_d = PS2_ERR_XFER_TO;
                    state_d    = PS2_IDLE;
                end else if (clk_fall) begin
                    bit_d = bit_q + 4'd1;
                    if (bit_q == 4'd9) begin
                        drive_d = 1'b0;         // stop bit: release data
                        state_d = PS2_ACK;
                    end else begin
                        drive_d = ~sh_q[0];
                        sh_d    = sh_q >> 1;
                    end
                end
            end
            PS2_ACK: begin
                if (xfer_expired) begin
                    err_d      = 1'b1;
                    err_code_d = PS2_ERR_XFER_TO;
                    state_d    = PS2_IDLE;
                end else if (clk_fall) begin
                    bit_d = 4'd11;
                    if (data_sync) begin
                        err_d      = 1'b1;
                        err_code_d = PS2_ERR_NACK;
                        state_d    = PS2_IDLE;
                    end else begin
                        state_d = PS2_WAITIDLE;
                    end
                end
            end
            PS2_WAITIDLE: begin
                if (xfer_expired) begin
                    err_d      = 1'b1;
                    err_code_d = PS2_ERR_XFER_TO;
                    state_d    = PS2_IDLE;
                end else if (clk_sync && data_sync) begin
                    done_d  = 1'b1;
                    state_d = PS2_IDLE;
                end
            end
            default: state_d = PS2_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= PS2_IDLE;
            bit_q      <= '0;
            tmo_q      <= '0;
            sh_q       <= '0;
            drive_q    <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            err_code_q <= PS2_ERR_NONE;
        end else begin
            state_q    <= state_d;
            bit_q      <= bit_d;
            tmo_q      <= tmo_d;
            sh_q       <= sh_d;
            drive_q    <= drive_d;
            done_q     <= done_d;
            err_q      <= err_d;
            err_code_q <= err_code_d;
        end
    end

    // Line drives decode straight from state so any return to IDLE (error
    // or reset) releases both lines in the same cycle.
    assign tx_ready    = (state_q == PS2_IDLE);
    assign busy        = ~tx_ready;
    assign done        = done_q;
    assign err         = err_q;
    assign err_code    = err_code_q;
    assign ps2_clk_oe  = (state_q == PS2_INHIBIT) || (state_q == PS2_START);
    assign ps2_data_oe = (state_q == PS2_START) || (state_q == PS2_RELEASE) ||
                         ((state_q == PS2_SHIFT) && drive_q);

endmodule
